// File: rtl/mrelbp_hist_pkg.sv
// Shared types and constants for the NI/RD histogram readout sequencer.
package mrelbp_hist_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SEND_NI = 3'd3,
    ST_SEND_RD = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Feature index spans NI and RD bins: one extra bit over the bin address.
  function automatic int unsigned feat_idx_w(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mrelbp_hist_readout.sv
// Histogram readout sequencer: on a frame-done pulse, sweeps every bin of the
// NI and RD histogram RAMs (1-cycle read latency) and streams the counts as a
// 2*DEPTH-beat feature vector over valid/ready.
// Optional macro HIST_CLEAR_EN: zero each bin after it has been read out.
module mrelbp_hist_readout
  import mrelbp_hist_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = mrelbp_hist_pkg::CNT_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic [WIDTH-1:0]             o_addr,
  input  logic [CNT_W-1:0]             i_ni_count,
  input  logic [CNT_W-1:0]             i_rd_count,
  output logic                         o_clr_wren,
  output logic                         o_feat_valid,
  input  logic                         i_feat_ready,
  output logic [CNT_W-1:0]             o_feat_data,
  output logic [feat_idx_w(WIDTH)-1:0] o_feat_index,
  output logic                         o_feat_last,
  output logic                         o_done
);

  localparam int unsigned IDX_W = feat_idx_w(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   rd_cap_q, rd_cap_d;
  logic [CNT_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               last_q, last_d;
  logic               busy_q, valid_q, done_q;
  logic               last_bin;

  assign last_bin = (bin_q == WIDTH'(DEPTH - 1));

  // Next-state decode; output beat contents are prepared one cycle ahead so
  // every feature output comes straight from a register.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    rd_cap_d = rd_cap_q;
    data_d   = data_q;
    index_d  = index_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ISSUE;
          bin_d   = '0;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // NI count goes straight into the output register; RD is held back.
        rd_cap_d = i_rd_count;
        data_d   = i_ni_count;
        index_d  = {bin_q, 1'b0};
        last_d   = 1'b0;
        state_d  = ST_SEND_NI;
      end
      ST_SEND_NI: begin
        if (i_feat_ready) begin
          data_d  = rd_cap_q;
          index_d = {bin_q, 1'b1};
          last_d  = last_bin;
          state_d = ST_SEND_RD;
        end
      end
      ST_SEND_RD: begin
        if (i_feat_ready) begin
          last_d = 1'b0;
`ifdef HIST_CLEAR_EN
          state_d = ST_CLEAR;
`else
          if (last_bin) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            bin_d   = bin_q + 1'b1;
          end
`endif
        end
      end
`ifdef HIST_CLEAR_EN
      ST_CLEAR: begin
        if (last_bin) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
          bin_d   = bin_q + 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        bin_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      rd_cap_q <= '0;
      data_q   <= '0;
      index_q  <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      rd_cap_q <= rd_cap_d;
      data_q   <= data_d;
      index_q  <= index_d;
      last_q   <= last_d;
      busy_q   <= (state_d != ST_IDLE);
      valid_q  <= (state_d == ST_SEND_NI) || (state_d == ST_SEND_RD);
      done_q   <= (state_d == ST_DONE);
    end
  end

`ifdef HIST_CLEAR_EN
  logic clr_q;

  // Clear strobe for the bin just read out; write data is implicitly zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) clr_q <= 1'b0;
    else       clr_q <= (state_d == ST_CLEAR);
  end

  assign o_clr_wren = clr_q;
`else
  assign o_clr_wren = 1'b0;
`endif

  assign o_busy       = busy_q;
  assign o_addr       = bin_q;
  assign o_feat_valid = valid_q;
  assign o_feat_data  = data_q;
  assign o_feat_index = index_q;
  assign o_feat_last  = last_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_mrelbp_hist_readout.sv
// Self-checking bench for mrelbp_hist_readout with a behavioural NI/RD RAM.
module tb_mrelbp_hist_readout;
  import mrelbp_hist_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CW    = CNT_W;
  localparam int unsigned IW    = WIDTH + 1;
  localparam int unsigned NBEAT = 2 * DEPTH;
`ifdef HIST_CLEAR_EN
  localparam int CPB     = 5;
  localparam int CLR_EXP = DEPTH;
`else
  localparam int CPB     = 4;
  localparam int CLR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, ready;
  logic busy, clr, valid, last, done;
  logic [WIDTH-1:0] addr;
  logic [CW-1:0] ni_q, rd_q, data;
  logic [IW-1:0] index;

  always #5 clk = ~clk;

  mrelbp_hist_readout #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_addr(addr),
    .i_ni_count(ni_q), .i_rd_count(rd_q), .o_clr_wren(clr),
    .o_feat_valid(valid), .i_feat_ready(ready), .o_feat_data(data),
    .o_feat_index(index), .o_feat_last(last), .o_done(done)
  );

  // Histogram RAM model: 1-cycle read latency, read-before-clear.
  logic [CW-1:0] ni_mem [DEPTH];
  logic [CW-1:0] rd_mem [DEPTH];
  always @(posedge clk) begin
    ni_q <= ni_mem[addr];
    rd_q <= rd_mem[addr];
    if (clr) begin
      ni_mem[addr] = '0;
      rd_mem[addr] = '0;
    end
  end

  typedef struct packed {
    logic [CW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned beats, done_cnt, clr_cnt;
  logic [CW-1:0] cap_data [NBEAT];
  logic          cap_last [NBEAT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: sample on the falling edge, pop/compare on each handshake.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (done) done_cnt++;
      if (clr) begin
        chk("clr_addr", 64'(addr), 64'(clr_cnt % DEPTH));
        clr_cnt++;
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat: got index %0d, want no beat", index);
        end else begin
          e = sb.pop_front();
          chk("beat_idx", 64'(index), 64'(e.idx));
          chk("beat_data", 64'(data), 64'(e.data));
          chk("beat_last", 64'(last), 64'(e.last));
        end
        cap_data[index] = data;
        cap_last[index] = last;
        beats++;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_busy",  64'(busy),  0);
    chk("rst_addr",  64'(addr),  0);
    chk("rst_clr",   64'(clr),   0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_data",  64'(data),  0);
    chk("rst_index", 64'(index), 0);
    chk("rst_last",  64'(last),  0);
    chk("rst_done",  64'(done),  0);
  endtask

  task automatic preload_base();
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ni_mem[k] = CW'(k);
      rd_mem[k] = CW'(1000 + k);
    end
  endtask

  // mode 0: ready held high; mode 1: 5-cycle stall on index 7, then random.
  task automatic run_sweep(input int mode, input bit busy_starts, input int rst_at, input bit chk_time);
    int cyc = 0;
    int stall = 0;
    int first_v = -1;
    int done_c = -1;
    bit rst_done = 1'b0;
    logic [CW-1:0] rd3;
    rd3 = rd_mem[3];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      sb.push_back('{data: ni_mem[k], idx: IW'(2 * k), last: 1'b0});
      sb.push_back('{data: rd_mem[k], idx: IW'(2 * k + 1), last: (k == DEPTH - 1)});
    end
    beats = 0; done_cnt = 0; clr_cnt = 0;
    ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    while ((done_c < 0 || cyc < done_c + 3) && cyc < 8000) begin
      @(posedge clk); #1;
      cyc++;
      if (rst_at > 0 && beats >= rst_at) begin
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_reset_outputs();
        sb.delete();
        rst_done = 1'b1;
        break;
      end
      if (valid && first_v < 0) first_v = cyc;
      if (done && done_c < 0) done_c = cyc;
      start = busy_starts && (cyc == 100 || done);
      if (mode == 1) begin
        if (valid && index == IW'(7) && stall < 5) begin
          chk("stall_data", 64'(data), 64'(rd3));
          stall++;
          ready = 1'b0;
        end else if (stall >= 5) begin
          ready = 1'($urandom_range(0, 1));
        end else begin
          ready = 1'b1;
        end
      end
    end
    start = 1'b0;
    ready = 1'b1;
    if (rst_at > 0) begin
      chk("rst_reached", 64'(rst_done), 1);
    end else begin
      chk("done_seen", 64'(done_c >= 0), 1);
      if (chk_time) begin
        chk("first_valid_cyc", 64'(first_v), 3);
        chk("done_cyc", 64'(done_c), 64'(DEPTH * CPB + 1));
      end
      chk("done_pulses", 64'(done_cnt), 1);
      chk("sb_empty", 64'(sb.size()), 0);
      chk("beat_count", 64'(beats), 64'(NBEAT));
      chk("busy_after", 64'(busy), 0);
      chk("clr_count", 64'(clr_cnt), 64'(CLR_EXP));
      if (mode == 1) chk("stall_cycles", 64'(stall), 5);
    end
  endtask

  typedef struct {
    int unsigned   bin;
    logic [CW-1:0] ni;
    logic [CW-1:0] rd;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int unsigned bad;
    tbl[0] = '{255, 24'hFFFFFF, 24'd1255};
    tbl[1] = '{0,   24'd5,      24'd0};
    tbl[2] = '{128, 24'h800000, 24'h7FFFFF};
    tbl[3] = '{1,   24'hFFFFFE, 24'd1};

    rst = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b0;

    // Constant ready, with latency checks.
    preload_base();
    run_sweep(0, 1'b0, 0, 1'b1);

    // Backpressure on index 7, then random ready.
    preload_base();
    run_sweep(1, 1'b0, 0, 1'b0);

    // Start pulses while busy and during DONE are ignored.
    preload_base();
    run_sweep(0, 1'b1, 0, 1'b1);

    // Reset at beat 200, then a fresh sweep from index 0.
    preload_base();
    run_sweep(0, 1'b0, 200, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk("post_rst_valid", 64'(valid), 0);
    preload_base();
    run_sweep(0, 1'b0, 0, 1'b1);

    // Back-to-back sweeps: second returns zeros only when clearing is built.
    preload_base();
    run_sweep(0, 1'b0, 0, 1'b0);
    run_sweep(0, 1'b0, 0, 1'b0);
    bad = 0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
`ifdef HIST_CLEAR_EN
      if (cap_data[2 * k] !== '0 || cap_data[2 * k + 1] !== '0) bad++;
`else
      if (cap_data[2 * k] !== CW'(k) || cap_data[2 * k + 1] !== CW'(1000 + k)) bad++;
`endif
    end
    chk("second_sweep_bins", 64'(bad), 0);

    // Extreme counts pass through unaltered.
    preload_base();
    for (int i = 0; i < 4; i++) begin
      ni_mem[tbl[i].bin] = tbl[i].ni;
      rd_mem[tbl[i].bin] = tbl[i].rd;
    end
    run_sweep(0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("tbl_ni_data", 64'(cap_data[2 * tbl[i].bin]), 64'(tbl[i].ni));
      chk("tbl_rd_data", 64'(cap_data[2 * tbl[i].bin + 1]), 64'(tbl[i].rd));
      chk("tbl_ni_last", 64'(cap_last[2 * tbl[i].bin]), 0);
      chk("tbl_rd_last", 64'(cap_last[2 * tbl[i].bin + 1]), 64'(tbl[i].bin == DEPTH - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mrelbp_hist_readout.md
Name: mrelbp_hist_readout

Overview:
Readout sequencer downstream of the NI/RD histogram memories. On a frame-done pulse it sweeps every bin address, takes the NI and RD counts from the 1-cycle-latency RAM read ports, and streams them as a 2*DEPTH-entry feature vector over a valid/ready interface to the classifier stage. With HIST_CLEAR_EN it also zeroes each bin after readout, so the histogram is ready for the next frame.

Parameters:
WIDTH, 8, bin address width
DEPTH, 256, bins per histogram; must equal 2**WIDTH
CNT_W, 24, bin count width

Ports:
i_clk  in  1  global clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  frame-done pulse; starts a sweep
o_busy  out  1  high whenever state is not IDLE
o_addr  out  WIDTH  bin address driven to both NI and RD histogram RAMs
i_ni_count  in  CNT_W  NI RAM read data, valid 1 cycle after address is sampled
i_rd_count  in  CNT_W  RD RAM read data, same timing
o_clr_wren  out  1  clear-write strobe to the histogram mux; write data is 0
o_feat_valid  out  1  feature beat valid
i_feat_ready  in  1  consumer ready
o_feat_data  out  CNT_W  bin count
o_feat_index  out  WIDTH+1  feature index: 2k = NI[k], 2k+1 = RD[k]
o_feat_last  out  1  high on index 2*DEPTH-1
o_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset values: state IDLE; o_addr, bin counter, o_busy, o_clr_wren, o_feat_valid, o_feat_data, o_feat_index, o_feat_last and o_done all 0. Capture registers are 0.
- FSM states: IDLE, ISSUE, WAIT, SEND_NI, SEND_RD, CLEAR (macro only), DONE.
- IDLE: if i_start=1, go to ISSUE with bin=0. Otherwise stay.
- ISSUE: o_addr=bin. RAM samples the address at the end of this cycle. Next state is WAIT.
- WAIT: at the end of the cycle, capture i_ni_count and i_rd_count into the hold registers. Next state is SEND_NI.
- SEND_NI: o_feat_valid=1, data=NI capture, index=2*bin. Stay until i_feat_ready=1, then go to SEND_RD.
- SEND_RD: o_feat_valid=1, data=RD capture, index=2*bin+1. On handshake:
  - with the macro, go to CLEAR;
  - without it, go to DONE if bin==DEPTH-1, otherwise to ISSUE with bin+1.
- DONE: o_done=1 for exactly 1 cycle, then IDLE.
- Handshake rules:
  - a beat transfers when valid and ready are both high;
  - while valid=1 and ready=0, data, index and last stay stable;
  - valid never drops before its handshake.
  - Outputs are registered, with no combinational path from ready to valid.
- Latency: a start edge at cycle 0 gives first valid at cycle 3. With ready held high, a sweep takes 4 cycles per bin (5 with the macro), plus the DONE cycle.
- End of sweep: detected by comparing bin to DEPTH-1, not by counter overflow. The bin counter never wraps mid-sweep.
- i_start while busy (including DONE): ignored. No queuing, no restart.
- Reset mid-sweep: everything returns to reset values on the next edge. Any partially sent beat is dropped. o_clr_wren is guaranteed low the cycle after reset.
- Counts pass through unmodified; there is no saturation or arithmetic on the data path.

Optional Feature:
Macro: HIST_CLEAR_EN
- Defined: after the SEND_RD handshake, the block spends one CLEAR cycle with o_clr_wren=1 and o_addr=bin. It then goes to ISSUE with bin+1, or to DONE after the last bin. After a sweep, every bin is 0.
- Undefined: the CLEAR state is not built, o_clr_wren is tied to 0, and histogram contents are untouched.

Decomposition:
- Package mrelbp_hist_pkg holds:
  - the state enum type;
  - localparam CNT_W=24;
  - the feature-index width helper (WIDTH+1).
- No sub-module. The capture registers and output registers are inline, and the FSM is small enough for a single module.

Test Plan:
1. Sweep with constant ready: preload NI[k]=k and RD[k]=1000+k, hold ready=1, pulse start.
   - Expect 512 beats in order 0, 1000, 1, 1001, …, 255, 1255 with indices 0..511.
   - last high only on index 511; o_done 1 cycle after the final beat.
   - Total 1024 cycles (1280 with the macro) plus DONE.
2. Backpressure: hold ready=0 for 5 cycles while index 7 is presented, then toggle ready randomly for the rest of the sweep.
   - Index 7 stays stable with data=RD[3] throughout the stall.
   - No beat is lost or duplicated; the full sequence matches scenario 1.
3. Start while busy: pulse start again at cycle 100 and during DONE.
   - Exactly one sweep of 512 beats occurs; o_done pulses once.
4. Reset mid-sweep: assert i_rst at beat 200.
   - Next cycle all outputs are 0 and the state is IDLE.
   - A fresh start restarts from index 0 with correct data.
5. HIST_CLEAR_EN defined: run two back-to-back sweeps.
   - The second sweep returns all zeros.
   - o_clr_wren pulses 256 times, with o_addr 0..255 in order.
   - Macro undefined: o_clr_wren is never high and the second sweep returns the same values as the first.
6. Maximum count: preload NI[255]=24'hFFFFFF and RD[0]=0.
   - Beat 510 carries FFFFFF and beat 1 carries 0, both unaltered, with last on index 511.
